muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU. Sits directly downstream of the register file: its operand inputs come straight from the Rs/Rt read ports.
- Holds the architectural HI/LO registers. MFHI/MFLO results go back to the register-file write port through the existing writeback mux.
- Completes one bit per clock, so the core stalls on busy while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, 32, number of iteration cycles; must equal WIDTH.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ena  input  1  global enable; when low, all state is frozen.
- start  input  1  one-cycle request to begin the operation selected by op.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  Rs operand (multiplicand or dividend).
- b  input  WIDTH  Rt operand (multiplier or divisor).
- we_hi  input  1  MTHI write strobe.
- we_lo  input  1  MTLO write strobe.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse: HI/LO updated.
- hi  output  WIDTH  HI register (remainder, or upper product).
- lo  output  WIDTH  LO register (quotient, or lower product).

Behaviour:
- Reset (asynchronous, any time, including mid-operation): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0. Any in-flight operation is discarded.
- ena=0: no state, counter, hi, lo or done change at the edge. A done pulse pending on that edge is deferred until the next enabled edge. hi/lo are always driven; no high-Z.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - FIX: busy=1.
- IDLE -> RUN on an enabled edge with start=1. At that edge (E0):
  - latch op and the operand magnitudes (absolute values for MULT/DIV; raw values for MULTU/DIVU);
  - latch the result-sign flags and original a;
  - counter=0.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per enabled edge. After ITER steps (edge E32), go to FIX.
- FIX -> IDLE at edge E33. At that edge:
  - apply sign fixup and write hi/lo;
  - done=1 for exactly the following cycle.
- Latency: results are visible 33 enabled edges after the accepting edge. busy is high from after E0 through E33.
- Multiply: 64-bit product {hi,lo}. Signed MULT negates the product when the operand signs differ.
- Divide: lo=quotient, hi=remainder. Signed DIV:
  - quotient negated when signs differ;
  - remainder takes the sign of the dividend.
- Divide by zero (b=0, DIV or DIVU): hi=original a, lo=all ones; no sign fixup. Still takes the full 33 cycles.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- start while busy: ignored; the in-flight operation is unaffected.
- we_hi/we_lo:
  - In IDLE, the enabled edge writes wdata into hi/lo and produces no done.
  - Ignored while busy.
  - we_hi and we_lo together write both registers.
- start together with we_hi/we_lo in IDLE: the write takes effect at E0 and the operation still starts; its result overwrites hi/lo at E33.
- done is combinationally independent of the inputs (registered).

Decomposition:
- Package muldiv_pkg:
  - op encodings OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11;
  - state encodings S_IDLE, S_RUN, S_FIX;
  - default ITER=32.
- Single module; no sub-module is needed. The step datapath and sign fixup stay inline as combinational blocks.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 33 edges, done pulse once, hi=0xFFFFFFFE lo=0x00000001.
- MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; then DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
- DIVU a=0x64 b=0 -> hi=0x00000064 lo=0xFFFFFFFF after 33 edges; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
- Start DIVU 100/7, pulse start again (MULTU 2*2) and we_hi=1 wdata=0x1234 at cycle 10 -> both ignored; final lo=14 hi=2.
- Start MULTU 3*4, hold ena=0 for 5 cycles mid-run -> done arrives 38 edges after accept, lo=12 hi=0; MTLO 0xABCD in IDLE -> lo=0xABCD next cycle, done stays 0.
- Assert rst asynchronously at cycle 15 of a DIV -> busy=0 done=0 hi=lo=0 immediately; the next op after release completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op and state encodings plus the default iteration count for muldiv_unit
package muldiv_pkg;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  localparam int ITER_DEF = 32;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers, one bit per clock
// ports: clk/rst(async, high)/ena; start+op+a+b request an op; we_hi/we_lo+wdata are MTHI/MTLO;
//        busy while in flight, done pulses when hi/lo take a result
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = ITER_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(ITER + 1);
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             div_q, neg_q, rneg_q, dz_q, done_q;
  logic [WIDTH-1:0] m_q, wh_q, wl_q, a_q, hi_q, lo_q;
  logic             sgn, ge;
  logic [WIDTH-1:0] abs_a, abs_b, step_hi, step_lo, fix_hi, fix_lo;
  logic [WIDTH:0]   sum, t;
  logic [2*WIDTH-1:0] prod;
  assign sgn   = ~op[0];
  assign abs_a = (sgn && a[WIDTH-1]) ? -a : a;
  assign abs_b = (sgn && b[WIDTH-1]) ? -b : b;
  // wh_q/wl_q: multiply keeps {partial product, multiplier} shifting right;
  // divide keeps {remainder, dividend/quotient} shifting left
  always_comb begin
    sum     = {1'b0, wh_q} + (wl_q[0] ? {1'b0, m_q} : '0);
    t       = {wh_q, wl_q[WIDTH-1]};
    ge      = t >= {1'b0, m_q};
    step_hi = div_q ? (ge ? t[WIDTH-1:0] - m_q : t[WIDTH-1:0]) : sum[WIDTH:1];
    step_lo = div_q ? {wl_q[WIDTH-2:0], ge} : {sum[0], wl_q[WIDTH-1:1]};
    prod    = neg_q ? -{wh_q, wl_q} : {wh_q, wl_q};
    fix_hi  = !div_q ? prod[2*WIDTH-1:WIDTH] : dz_q ? a_q : rneg_q ? -wh_q : wh_q;
    fix_lo  = !div_q ? prod[WIDTH-1:0] : dz_q ? '1 : neg_q ? -wl_q : wl_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      m_q     <= '0;
      wh_q    <= '0;
      wl_q    <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (ena) begin
      done_q <= state_q == S_FIX;
      case (state_q)
        S_IDLE: begin
          if (we_hi) hi_q <= wdata;
          if (we_lo) lo_q <= wdata;
          if (start) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            div_q   <= op[1];
            m_q     <= op[1] ? abs_b : abs_a;
            wh_q    <= '0;
            wl_q    <= op[1] ? abs_a : abs_b;
            neg_q   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_q  <= sgn & a[WIDTH-1];
            dz_q    <= op[1] & (b == '0);
            a_q     <= a;
          end
        end
        S_RUN: begin
          wh_q  <= step_hi;
          wl_q  <= step_lo;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(ITER - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign busy = state_q != S_IDLE;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  import muldiv_pkg::*;
  localparam int W = 32;
  logic clk = 0, rst = 1, ena = 1, start = 0, we_hi = 0, we_lo = 0;
  logic [1:0] op = 0;
  logic [W-1:0] a = 0, b = 0, wdata = 0;
  logic busy, done;
  logic [W-1:0] hi, lo;
  typedef struct {logic [W-1:0] hi; logic [W-1:0] lo; int acc;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int compared = 0, mismatched = 0, en_edges = 0, cycles = 0;
  muldiv_unit #(.WIDTH(W), .ITER(32)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .op(op), .a(a), .b(b),
    .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cycles++;
    if (ena && !rst) en_edges++;
  end
  function automatic void check(string n, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction
  function automatic exp_t model(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y);
    exp_t e;
    logic [63:0] p;
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == OP_MULT) p = 64'(sx * sy);
    else if (o == OP_MULTU) p = {32'b0, x} * {32'b0, y};
    else if (y == 0) p = {x, 32'hFFFF_FFFF};
    else if (o == OP_DIV) p = {32'(sx % sy), 32'(sx / sy)};
    else p = {x % y, x / y};
    e.hi = p[63:32];
    e.lo = p[31:0];
    e.acc = 0;
    return e;
  endfunction
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (hi=%h lo=%h)", hi, lo);
      end else begin
        mon_e = sb.pop_front();
        check("result_hi", 64'(hi), 64'(mon_e.hi));
        check("result_lo", 64'(lo), 64'(mon_e.lo));
        check("latency_enabled_edges", 64'(en_edges - mon_e.acc), 64'd33);
      end
    end
  end
  task automatic issue(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y,
                       logic wh = 0, logic wl = 0, logic [W-1:0] wd = 0);
    exp_t e;
    @(negedge clk);
    op = o; a = x; b = y; start = 1; we_hi = wh; we_lo = wl; wdata = wd;
    @(posedge clk);
    #1;
    start = 0; we_hi = 0; we_lo = 0;
    e = model(o, x, y);
    e.acc = en_edges;
    sb.push_back(e);
    check("busy_on_accept", 64'(busy), 64'd1);
  endtask
  task automatic wait_idle();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_within_bound", 64'(i < 300), 64'd1);
    @(negedge clk);
  endtask
  initial begin
    int c0, i;
    logic [W-1:0] h0, ra, rb;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 0);
    check("reset_done", 64'(done), 0);
    check("reset_hi", 64'(hi), 0);
    check("reset_lo", 64'(lo), 0);
    rst = 0;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);           wait_idle();
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);            wait_idle();
    issue(OP_DIVU, 32'h64, 32'd0);                  wait_idle();
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);    wait_idle();
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);            wait_idle();
    // start and MTHI while busy must both be ignored
    h0 = hi;
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    op = OP_MULTU; a = 2; b = 2; start = 1; we_hi = 1; wdata = 32'h1234;
    @(negedge clk);
    start = 0; we_hi = 0;
    check("mthi_ignored_busy", 64'(hi), 64'(h0));
    check("busy_after_ignored_start", 64'(busy), 1);
    wait_idle();
    // enable gap mid-run stretches wall-clock latency by the gap
    issue(OP_MULTU, 32'd3, 32'd4);
    c0 = cycles;
    repeat (5) @(negedge clk);
    ena = 0;
    repeat (5) @(negedge clk);
    ena = 1;
    for (i = 0; i < 100; i++) begin
      if (done) break;
      @(negedge clk);
    end
    check("ena_gap_latency", 64'(cycles - c0), 64'd38);
    wait_idle();
    @(negedge clk); we_lo = 1; wdata = 32'hABCD;
    @(negedge clk); we_lo = 0;
    check("mtlo_lo", 64'(lo), 64'hABCD);
    check("mtlo_hi_kept", 64'(hi), 0);
    check("mtlo_no_done", 64'(done), 0);
    we_hi = 1; we_lo = 1; wdata = 32'h5A5A_0F0F;
    @(negedge clk); we_hi = 0; we_lo = 0;
    check("mt_both_hi", 64'(hi), 64'h5A5A_0F0F);
    check("mt_both_lo", 64'(lo), 64'h5A5A_0F0F);
    check("mt_both_no_done", 64'(done), 0);
    // write in the accepting cycle lands at E0, result overwrites at E33
    issue(OP_MULTU, 32'd6, 32'd7, 1'b1, 1'b0, 32'hBEEF);
    check("start_with_mthi_hi", 64'(hi), 64'hBEEF);
    wait_idle();
    // async reset mid-operation discards it
    issue(OP_DIV, 32'hFFFF_FF9C, 32'd3);
    repeat (15) @(negedge clk);
    #2 rst = 1;
    #1;
    check("async_rst_busy", 64'(busy), 0);
    check("async_rst_done", 64'(done), 0);
    check("async_rst_hi", 64'(hi), 0);
    check("async_rst_lo", 64'(lo), 0);
    sb.delete();
    @(negedge clk);
    rst = 0;
    issue(OP_DIV, 32'hFFFF_FF9C, 32'd3); wait_idle();
    for (int k = 0; k < 40; k++) begin
      ra = $urandom_range(0, 5) == 0 ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: rb = 0;
        1: rb = $urandom_range(1, 20);
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      issue(2'($urandom_range(0, 3)), ra, rb);
      wait_idle();
    end
    check("scoreboard_drained", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
